fsm_cmd_conditioner: RTL and testbench

//   Upstream stage of the control FSM. Takes the asynchronous 3-bit user command bus
//   and synchronises, debounces and legality-checks it. Issues each accepted command

---
 rtl/fsm_cmd_conditioner.sv | 111 +++++++++++
 tb/tb_fsm_cmd_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_conditioner.sv
// Command conditioner ahead of the control FSM: synchronises, debounces and
// legality-checks the raw user command bus, emitting each accepted code once.
module fsm_cmd_conditioner #(
  parameter int CMD_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] raw_cmd,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_valid,
  output logic             cmd_reject,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    EMIT    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_MIN  = CNT_W'(HOLD_CYCLES);
  localparam logic [CMD_W-1:0] LEGAL_LIM = CMD_W'(4);

  logic [CMD_W-1:0] sync_1;
  logic [CMD_W-1:0] sync_q;
  logic [CMD_W-1:0] candidate;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  // raw_cmd is asynchronous; nothing downstream may look at it before sync_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_q <= '0;
    end else begin
      sync_1 <= raw_cmd;
      sync_q <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      candidate  <= '0;
      cnt        <= '0;
      cmd_out    <= '0;
      cmd_valid  <= 1'b0;
      cmd_reject <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins, so each
      // strobe lasts exactly one cycle without extra clearing logic.
      cmd_valid  <= 1'b0;
      cmd_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q != '0) begin
            candidate <= sync_q;
            cnt       <= CNT_W'(1);
            state     <= SETTLE;
            busy      <= 1'b1;
          end
        end
        SETTLE: begin
          if (sync_q != candidate) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == DEB_MAX) begin
            // Strobes are raised on the transition edge so they are visible
            // during the EMIT cycle (or the first LOCKOUT cycle for a reject).
            if (candidate < LEGAL_LIM) begin
              cmd_out   <= candidate;
              cmd_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              cmd_reject <= 1'b1;
              cnt        <= '0;
              state      <= LOCKOUT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EMIT: begin
          cnt   <= '0;
          state <= LOCKOUT;
        end
        LOCKOUT: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          // A held key keeps us here; only a release re-arms the detector.
          if (cnt >= HOLD_MIN && sync_q == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_cmd_conditioner.sv
// Scenario bench for fsm_cmd_conditioner: expected strobes are queued with the
// cycle they must appear in, and a negedge monitor pops and compares them.
module tb_fsm_cmd_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw_cmd = 3'd0;
  logic [2:0] cmd_out;
  logic       cmd_valid;
  logic       cmd_reject;
  logic       busy;

  fsm_cmd_conditioner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_cmd   (raw_cmd),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .cmd_reject(cmd_reject),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    int         cyc;
  } exp_t;

  exp_t       vq[$];
  int         rq[$];
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  logic [2:0] last_cmd = 3'd0;
  logic       prev_strobe = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: every strobe must match the head of its queue, in the right cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (cmd_valid || cmd_reject) begin
        total++;
        if (prev_strobe || (cmd_valid && cmd_reject))
          $display("FAIL strobe_shape cyc=%0d valid=%b reject=%b prev=%b required isolated single strobe",
                   cyc, cmd_valid, cmd_reject, prev_strobe);
        else passed++;
      end
      if (cmd_valid) begin
        total++;
        if (vq.size() == 0) begin
          $display("FAIL unexpected_valid cyc=%0d cmd_out=%0d required no strobe", cyc, cmd_out);
        end else begin
          exp_t e;
          e = vq.pop_front();
          if (cmd_out !== e.cmd || cyc != e.cyc)
            $display("FAIL valid_match got cmd=%0d cyc=%0d required cmd=%0d cyc=%0d",
                     cmd_out, cyc, e.cmd, e.cyc);
          else passed++;
          last_cmd = e.cmd;
        end
      end
      if (cmd_reject) begin
        total++;
        if (rq.size() == 0) begin
          $display("FAIL unexpected_reject cyc=%0d required no strobe", cyc);
        end else begin
          int ec;
          ec = rq.pop_front();
          if (cyc != ec || cmd_out !== last_cmd)
            $display("FAIL reject_match got cyc=%0d cmd_out=%0d required cyc=%0d cmd_out=%0d",
                     cyc, cmd_out, ec, last_cmd);
          else passed++;
        end
      end
      prev_strobe = cmd_valid || cmd_reject;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((vq.size() != 0 || rq.size() != 0) && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (vq.size() != 0 || rq.size() != 0) begin
      $display("FAIL %s_missing_strobe pending_valid=%0d pending_reject=%0d required 0",
               name, vq.size(), rq.size());
      vq.delete();
      rq.delete();
    end else passed++;
  endtask

  task automatic check_busy(input string name, input logic exp);
    total++;
    if (busy !== exp) $display("FAIL %s busy=%b required %b", name, busy, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    raw_cmd = 3'd2;
    tick(3);
    total += 4;
    if (cmd_out !== 3'd0) $display("FAIL rst_cmd_out got %0d required 0", cmd_out); else passed++;
    if (cmd_valid !== 1'b0) $display("FAIL rst_valid got %b required 0", cmd_valid); else passed++;
    if (cmd_reject !== 1'b0) $display("FAIL rst_reject got %b required 0", cmd_reject); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b required 0", busy); else passed++;
    rst_n = 1'b1;
    vq.push_back('{cmd: 3'd2, cyc: cyc + 7});
    tick(12);
    drain("reset_first_cmd");
    check_busy("held_key_busy", 1'b1);
    raw_cmd = 3'd0;
    tick(6);
    check_busy("release_idle", 1'b0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      raw_cmd = (i % 2 == 0) ? 3'd1 : 3'd0;
      tick(1);
    end
    raw_cmd = 3'd0;
    tick(6);
    check_busy("bounce_idle", 1'b0);
    drain("bounce");
  endtask

  task automatic test_illegal();
    int c1;
    raw_cmd = 3'd6;
    rq.push_back(cyc + 7);
    tick(10);
    drain("illegal");
    check_busy("illegal_held_busy", 1'b1);
    raw_cmd = 3'd0;
    c1 = cyc;
    // Zero needs two edges through the synchroniser, then one edge to leave LOCKOUT.
    tick(2);
    check_busy("illegal_lockout_busy", 1'b1);
    tick(1);
    check_busy("illegal_exit_idle", 1'b0);
    total++;
    if (cyc != c1 + 3) $display("FAIL illegal_exit_cyc got %0d required %0d", cyc, c1 + 3);
    else passed++;
  endtask

  task automatic test_repeat();
    raw_cmd = 3'd3;
    vq.push_back('{cmd: 3'd3, cyc: cyc + 7});
    tick(20);
    drain("repeat_first");
    raw_cmd = 3'd0;
    tick(5);
    raw_cmd = 3'd3;
    vq.push_back('{cmd: 3'd3, cyc: cyc + 7});
    tick(10);
    drain("repeat_second");
    raw_cmd = 3'd0;
    tick(5);
  endtask

  task automatic test_change_mid_settle();
    raw_cmd = 3'd1;
    tick(3);
    raw_cmd = 3'd2;
    // The mismatch costs one IDLE cycle before 2 becomes the candidate: edge + 8.
    vq.push_back('{cmd: 3'd2, cyc: cyc + 8});
    tick(14);
    drain("change_mid_settle");
    raw_cmd = 3'd0;
    tick(5);
  endtask

  task automatic test_reset_mid_settle();
    raw_cmd = 3'd1;
    tick(5);
    rst_n = 1'b0;
    last_cmd = 3'd0;
    tick(2);
    total += 2;
    if (cmd_out !== 3'd0 || cmd_valid !== 1'b0)
      $display("FAIL midrst_outputs cmd_out=%0d valid=%b required 0/0", cmd_out, cmd_valid);
    else passed++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b required 0", busy); else passed++;
    rst_n = 1'b1;
    vq.push_back('{cmd: 3'd1, cyc: cyc + 7});
    tick(12);
    drain("reset_mid_settle");
    raw_cmd = 3'd0;
    tick(5);
    check_busy("final_idle", 1'b0);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_illegal();
    test_repeat();
    test_change_mid_settle();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
